// File: rtl/multicycle_control.sv
// Multicycle control unit for the load-store RISC-V datapath.
// Steps lw/sw/add/sub/addi/beq/bne through FETCH/DECODE/EXEC/MEM/WB/BRANCH and counts retired instructions.
module multicycle_control #(
    parameter int RETIRED_WIDTH   = 16,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     run,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic                     funct7_5,
    input  logic                     zero,
    output logic                     load_ir,
    output logic                     sub,
    output logic                     ULA_din2_sel,
    output logic                     RF_din_sel,
    output logic                     WE_RF,
    output logic                     WE_MEM,
    output logic                     load_pc,
    output logic                     pc_next_sel,
    output logic                     illegal,
    output logic                     busy,
    output logic [2:0]               state,
    output logic [RETIRED_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        BRANCH = 3'd5,
        TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    state_t st;
    logic   is_lw, is_sw, is_r, is_addi, is_br;

    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_r    = (opcode == OP_R);
    assign is_addi = (opcode == OP_ADDI);
    assign is_br   = (opcode == OP_BR) && (funct3[2:1] == 2'b00);

    // Strobes are registered for the state being entered, so each is a clean
    // function of the current state; only load_ir and pc_next_sel need to
    // follow run / zero within the cycle.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            st           <= FETCH;
            sub          <= 1'b0;
            ULA_din2_sel <= 1'b0;
            RF_din_sel   <= 1'b0;
            WE_RF        <= 1'b0;
            WE_MEM       <= 1'b0;
            load_pc      <= 1'b0;
            illegal      <= 1'b0;
            retired      <= '0;
        end else begin
            sub          <= 1'b0;
            ULA_din2_sel <= 1'b0;
            RF_din_sel   <= 1'b0;
            WE_RF        <= 1'b0;
            WE_MEM       <= 1'b0;
            load_pc      <= 1'b0;
            if (load_pc)
                retired <= retired + RETIRED_WIDTH'(1);
            case (st)
                FETCH: if (run) st <= DECODE;
                DECODE: begin
                    if (is_lw || is_sw || is_r || is_addi) begin
                        st           <= EXEC;
                        ULA_din2_sel <= ~is_r;
                        sub          <= is_r & funct7_5;
                    end else if (is_br) begin
                        st      <= BRANCH;
                        sub     <= 1'b1;
                        load_pc <= 1'b1;
                    end else if (TRAP_ON_ILLEGAL) begin
                        st      <= TRAP;
                        illegal <= 1'b1;
                    end else begin
                        st           <= WB;
                        ULA_din2_sel <= 1'b1;
                        load_pc      <= 1'b1;
                    end
                end
                EXEC: begin
                    if (is_lw || is_sw) begin
                        st           <= MEM;
                        ULA_din2_sel <= 1'b1;
                        WE_MEM       <= is_sw;
                        load_pc      <= is_sw;
                    end else begin
                        st           <= WB;
                        ULA_din2_sel <= ~is_r;
                        sub          <= is_r & funct7_5;
                        WE_RF        <= 1'b1;
                        RF_din_sel   <= 1'b1;
                        load_pc      <= 1'b1;
                    end
                end
                MEM: begin
                    if (is_sw) begin
                        st <= FETCH;
                    end else begin
                        st           <= WB;
                        ULA_din2_sel <= 1'b1;
                        WE_RF        <= 1'b1;
                        load_pc      <= 1'b1;
                    end
                end
                WB, BRANCH: st <= FETCH;
                TRAP:       st <= TRAP;
                default:    st <= FETCH;
            endcase
        end
    end

    assign load_ir     = (st == FETCH) & run & ~reset;
    assign pc_next_sel = (st == BRANCH) & (funct3[0] ? ~zero : zero);
    assign busy        = (st != FETCH);
    assign state       = st;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: trapping 16-bit instance and a NOP-on-illegal
// 2-bit-counter instance driven in parallel from a per-cycle vector table.
module tb_multicycle_control;

    localparam logic [6:0] LW = 7'h03, SW = 7'h23, RT = 7'h33, ADDI = 7'h13, BR = 7'h63, ILL = 7'h7F;

    logic       CLK = 1'b0;
    logic       reset, run, funct7_5, zero;
    logic [6:0] opcode;
    logic [2:0] funct3;

    logic        ld_ir_a, sub_a, d2_a, rfd_a, werf_a, wem_a, ldpc_a, pcns_a, ill_a, busy_a;
    logic [2:0]  state_a;
    logic [15:0] ret_a;
    logic        ld_ir_b, sub_b, d2_b, rfd_b, werf_b, wem_b, ldpc_b, pcns_b, ill_b, busy_b;
    logic [2:0]  state_b;
    logic [1:0]  ret_b;

    always #5 CLK = ~CLK;

    multicycle_control #(.RETIRED_WIDTH(16), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
        .CLK(CLK), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .load_ir(ld_ir_a), .sub(sub_a),
        .ULA_din2_sel(d2_a), .RF_din_sel(rfd_a), .WE_RF(werf_a), .WE_MEM(wem_a),
        .load_pc(ldpc_a), .pc_next_sel(pcns_a), .illegal(ill_a), .busy(busy_a),
        .state(state_a), .retired(ret_a));

    multicycle_control #(.RETIRED_WIDTH(2), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
        .CLK(CLK), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .load_ir(ld_ir_b), .sub(sub_b),
        .ULA_din2_sel(d2_b), .RF_din_sel(rfd_b), .WE_RF(werf_b), .WE_MEM(wem_b),
        .load_pc(ldpc_b), .pc_next_sel(pcns_b), .illegal(ill_b), .busy(busy_b),
        .state(state_b), .retired(ret_b));

    // {state, load_ir, sub, din2_sel, rf_din_sel, we_rf, we_mem, load_pc, pc_next_sel, illegal, busy}
    logic [13:0] obs_a, obs_b;
    assign obs_a = {state_a, ld_ir_a, sub_a, d2_a, rfd_a, werf_a, wem_a, ldpc_a, pcns_a, ill_a, busy_a};
    assign obs_b = {state_b, ld_ir_b, sub_b, d2_b, rfd_b, werf_b, wem_b, ldpc_b, pcns_b, ill_b, busy_b};

    typedef struct {
        logic       rst, run;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z;
        logic [2:0] st_a;
        logic [7:0] sb_a;
        logic       il_a;
        int         rt_a;
        logic [2:0] st_b;
        logic [7:0] sb_b;
        int         rt_b;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   passed = 0;

    function automatic void addx(logic r, logic rn, logic [6:0] op, logic [2:0] f3, logic f7, logic z,
                                 logic [2:0] sa, logic [7:0] ba, logic ia, int ra,
                                 logic [2:0] sbs, logic [7:0] bb, int rb);
        vec_t v;
        v.rst = r; v.run = rn; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z;
        v.st_a = sa; v.sb_a = ba; v.il_a = ia; v.rt_a = ra;
        v.st_b = sbs; v.sb_b = bb; v.rt_b = rb % 4;
        tbl.push_back(v);
    endfunction

    function automatic void addv(logic r, logic rn, logic [6:0] op, logic [2:0] f3, logic f7, logic z,
                                 logic [2:0] st, logic [7:0] sb, int ret);
        addx(r, rn, op, f3, f7, z, st, sb, 1'b0, ret, st, sb, ret);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    initial begin
        int n;
        // main flow: lw, add, sub, sw, bne(z=0), bne(z=1), beq(z=1), idle
        addv(1, 0, 7'h0, 0, 0, 0, 0, 8'h00, 0);
        addv(0, 1, LW, 0, 0, 0, 0, 8'h80, 0);
        addv(0, 1, LW, 0, 0, 0, 1, 8'h00, 0);
        addv(0, 1, LW, 0, 0, 0, 2, 8'h20, 0);
        addv(0, 1, LW, 0, 0, 0, 3, 8'h20, 0);
        addv(0, 1, LW, 0, 0, 0, 4, 8'h2A, 0);
        addv(0, 1, RT, 0, 0, 0, 0, 8'h80, 1);
        addv(0, 1, RT, 0, 0, 0, 1, 8'h00, 1);
        addv(0, 1, RT, 0, 0, 0, 2, 8'h00, 1);
        addv(0, 1, RT, 0, 0, 0, 4, 8'h1A, 1);
        addv(0, 1, RT, 0, 1, 0, 0, 8'h80, 2);
        addv(0, 1, RT, 0, 1, 0, 1, 8'h00, 2);
        addv(0, 1, RT, 0, 1, 0, 2, 8'h40, 2);
        addv(0, 1, RT, 0, 1, 0, 4, 8'h5A, 2);
        addv(0, 1, SW, 2, 0, 0, 0, 8'h80, 3);
        addv(0, 1, SW, 2, 0, 0, 1, 8'h00, 3);
        addv(0, 1, SW, 2, 0, 0, 2, 8'h20, 3);
        addv(0, 1, SW, 2, 0, 0, 3, 8'h26, 3);
        addv(0, 1, BR, 1, 0, 0, 0, 8'h80, 4);
        addv(0, 1, BR, 1, 0, 0, 1, 8'h00, 4);
        addv(0, 1, BR, 1, 0, 0, 5, 8'h43, 4);
        addv(0, 1, BR, 1, 0, 1, 0, 8'h80, 5);
        addv(0, 1, BR, 1, 0, 1, 1, 8'h00, 5);
        addv(0, 1, BR, 1, 0, 1, 5, 8'h42, 5);
        addv(0, 1, BR, 0, 0, 1, 0, 8'h80, 6);
        addv(0, 1, BR, 0, 0, 1, 1, 8'h00, 6);
        addv(0, 1, BR, 0, 0, 1, 5, 8'h43, 6);
        for (int i = 0; i < 5; i++) addv(0, 0, RT, 0, 0, 0, 0, 8'h00, 7);
        // illegal opcode: A traps and ignores run, B loops through NOPs
        addv(1, 0, 7'h0, 0, 0, 0, 0, 8'h00, 0);
        addv(0, 1, ILL, 0, 0, 0, 0, 8'h80, 0);
        addv(0, 1, ILL, 0, 0, 0, 1, 8'h00, 0);
        addx(0, 1, ILL, 0, 0, 0, 7, 8'h00, 1, 0, 4, 8'h22, 0);
        for (int k = 1; k <= 10; k++) begin
            int ph;
            ph = (k - 1) % 3;
            addx(0, 1, ILL, 0, 0, 0, 7, 8'h00, 1, 0,
                 (ph == 0) ? 3'd0 : (ph == 1) ? 3'd1 : 3'd4,
                 (ph == 0) ? 8'h80 : (ph == 1) ? 8'h00 : 8'h22,
                 1 + (k - 1) / 3);
        end
        // reset clears the sticky flag; then five addi to wrap the 2-bit counter
        addv(1, 1, 7'h0, 0, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            addv(0, 1, ADDI, 0, 0, 0, 0, 8'h80, i);
            addv(0, 1, ADDI, 0, 0, 0, 1, 8'h00, i);
            addv(0, 1, ADDI, 0, 0, 0, 2, 8'h20, i);
            addv(0, 1, ADDI, 0, 0, 0, 4, 8'h3A, i);
        end
        addv(0, 0, ADDI, 0, 0, 0, 0, 8'h00, 5);

        reset = 1'b1; run = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0;
        @(posedge CLK); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; run = tbl[i].run; opcode = tbl[i].op;
            funct3 = tbl[i].f3; funct7_5 = tbl[i].f7; zero = tbl[i].z;
            #1;
            chk($sformatf("row%0d_ctl_a", i), 32'(obs_a),
                32'({tbl[i].st_a, tbl[i].sb_a, tbl[i].il_a, tbl[i].st_a != 3'd0}));
            chk($sformatf("row%0d_ret_a", i), 32'(ret_a), 32'(tbl[i].rt_a));
            chk($sformatf("row%0d_ctl_b", i), 32'(obs_b),
                32'({tbl[i].st_b, tbl[i].sb_b, 1'b0, tbl[i].st_b != 3'd0}));
            chk($sformatf("row%0d_ret_b", i), 32'(ret_b), 32'(tbl[i].rt_b));
            @(posedge CLK); #1;
        end

        // asynchronous reset in the middle of an add's EXEC cycle
        reset = 1'b0; run = 1'b1; opcode = RT; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0;
        n = 0;
        while (state_a != 3'd2 && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("wait_exec", 32'(n < 10), 32'd1);
        chk("pre_reset_ret_a", 32'(ret_a), 32'd5);
        reset = 1'b1;
        #1;
        chk("async_rst_ctl_a", 32'(obs_a), 32'd0);
        chk("async_rst_ret_a", 32'(ret_a), 32'd0);
        chk("async_rst_ctl_b", 32'(obs_b), 32'd0);
        chk("async_rst_ret_b", 32'(ret_b), 32'd0);
        @(posedge CLK); #1;
        reset = 1'b0; run = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("post_rst_ctl_a", 32'(obs_a), 32'd0);
        chk("post_rst_ret_a", 32'(ret_a), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
